// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Arbitrates load-use stalls, multi-cycle MDU ops, EX redirects and fetch
// wait into PC / pipeline-register enables and bubble controls, and keeps
// saturating stall/flush performance counters.
module pipe_ctrl #(
  parameter int MDU_LAT = 32,  // total EX stall cycles per MDU op, 1..255
  parameter int CNT_W   = 16   // performance counter width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hzdlu,
  input  logic             EX_redirect,
  input  logic             EX_mdustart,
  input  logic             IF_ready,
  output logic             IF_pcen,
  output logic             pc_sel,
  output logic             ID_en,
  output logic             ID_flush,
  output logic             EX_en,
  output logic             EX_flush,
  output logic             MEM_flush,
  output logic             mdu_go,
  output logic             mdu_busy,
  output logic             mdu_done,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // The start cycle is the first stall cycle, so BUSY counts down from LAT-1.
  localparam logic [7:0]       LAT_M1  = 8'(MDU_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state, state_nxt;
  logic [7:0] mdu_cnt, mdu_cnt_nxt;
  logic       stall;       // freeze PC, IF/ID and ID/EX; bubble into EX/MEM
  logic       redir_take;  // redirect accepted this cycle

  // Next-state and all combinational pipeline controls.
  always_comb begin
    state_nxt   = state;
    mdu_cnt_nxt = mdu_cnt;
    stall       = 1'b0;
    redir_take  = 1'b0;
    IF_pcen     = 1'b1;
    pc_sel      = 1'b0;
    ID_en       = 1'b1;
    ID_flush    = 1'b0;
    EX_en       = 1'b1;
    EX_flush    = 1'b0;
    MEM_flush   = 1'b0;
    mdu_go      = 1'b0;
    mdu_busy    = 1'b0;
    mdu_done    = 1'b0;

    if (rst) begin
      // Hold the PC and push bubbles through every stage while in reset.
      IF_pcen   = 1'b0;
      ID_flush  = 1'b1;
      EX_flush  = 1'b1;
      MEM_flush = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          // Load-use wins: redirect/MDU decisions in EX use stale operands.
          if (hzdlu) begin
            stall = 1'b1;
          end else if (EX_mdustart) begin
            stall       = 1'b1;
            mdu_go      = 1'b1;
            state_nxt   = BUSY;
            mdu_cnt_nxt = LAT_M1;
          end else if (EX_redirect) begin
            redir_take = 1'b1;
          end
        end
        BUSY: begin
          mdu_busy = 1'b1;
          if (mdu_cnt != 8'd0) begin
            stall       = 1'b1;
            mdu_cnt_nxt = mdu_cnt - 8'd1;
          end else begin
            // Release cycle: pipeline advances, result lands in HI/LO.
            mdu_done  = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase

      if (stall) begin
        IF_pcen   = 1'b0;
        ID_en     = 1'b0;
        EX_en     = 1'b0;
        MEM_flush = 1'b1;
      end

      if (redir_take) begin
        // Outstanding fetch is abandoned, so the PC loads regardless of IF_ready.
        IF_pcen  = 1'b1;
        pc_sel   = 1'b1;
        ID_flush = 1'b1;
        EX_flush = 1'b1;
      end else if (!IF_ready) begin
        // Only bubble IF/ID when it would otherwise capture; a held
        // instruction must survive the stall.
        IF_pcen  = 1'b0;
        ID_flush = ID_en;
      end
    end
  end

  // FSM and MDU latency counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mdu_cnt <= 8'd0;
    end else begin
      state   <= state_nxt;
      mdu_cnt <= mdu_cnt_nxt;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!EX_en && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
      if (redir_take && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: three pipe_ctrl instances (different MDU_LAT / CNT_W) on
// shared inputs, compared every cycle against a cycle-schedule model, plus
// directed scenarios with literal expectations.
module tb_pipe_ctrl;

  localparam int NI = 3;
  localparam int LATS [NI] = '{12, 4, 1};
  localparam int CWS  [NI] = '{16, 4, 4};

  // Bit positions in the packed control vector.
  localparam int P_PCEN = 9, P_SEL = 8, P_IDEN = 7, P_IDF = 6, P_EXEN = 5;
  localparam int P_EXF = 4, P_MEMF = 3, P_GO = 2, P_BUSY = 1, P_DONE = 0;

  logic clk = 1'b0;
  logic rst = 1'b1, hzdlu = 1'b0, EX_redirect = 1'b0, EX_mdustart = 1'b0, IF_ready = 1'b1;

  wire [9:0]  ctl [NI];
  wire [15:0] stc [NI];
  wire [15:0] flc [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    logic pcen, sel, iden, idf, exen, exf, memf, go, busy, done;
    logic [CWS[gi]-1:0] sc, fc;
    pipe_ctrl #(.MDU_LAT(LATS[gi]), .CNT_W(CWS[gi])) dut (
      .clk(clk), .rst(rst), .hzdlu(hzdlu), .EX_redirect(EX_redirect),
      .EX_mdustart(EX_mdustart), .IF_ready(IF_ready),
      .IF_pcen(pcen), .pc_sel(sel), .ID_en(iden), .ID_flush(idf),
      .EX_en(exen), .EX_flush(exf), .MEM_flush(memf),
      .mdu_go(go), .mdu_busy(busy), .mdu_done(done),
      .stall_cnt(sc), .flush_cnt(fc)
    );
    assign ctl[gi] = {pcen, sel, iden, idf, exen, exf, memf, go, busy, done};
    assign stc[gi] = 16'(sc);
    assign flc[gi] = 16'(fc);
  end

  // ---------------- reference model ----------------
  // left[i]: MDU cycles still scheduled after the start cycle; the last one
  // is the release cycle, all earlier ones are stall cycles.
  int left [NI];
  int scnt [NI];
  int fcnt [NI];

  function automatic logic [9:0] exp_ctl(int lft, bit r, bit h, bit s, bit d, bit y);
    bit pcen = 1, sel = 0, iden = 1, idf = 0, exen = 1, exf = 0, memf = 0;
    bit go = 0, busy = 0, done = 0, stall = 0, redir = 0;
    if (r) return 10'b0011111000;
    if (lft > 1) begin stall = 1; busy = 1; end
    else if (lft == 1) begin busy = 1; done = 1; end
    else if (h) stall = 1;
    else if (s) begin stall = 1; go = 1; end
    else if (d) redir = 1;
    if (stall) begin pcen = 0; iden = 0; exen = 0; memf = 1; end
    if (redir) begin pcen = 1; sel = 1; idf = 1; exf = 1; end
    else if (!y) begin pcen = 0; idf = iden; end
    return {pcen, sel, iden, idf, exen, exf, memf, go, busy, done};
  endfunction

  // Compare every instance against the model each cycle, then advance it.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      logic [9:0] e;
      int mx;
      mx = (1 << CWS[i]) - 1;
      e = exp_ctl(left[i], rst, hzdlu, EX_mdustart, EX_redirect, IF_ready);
      checks++;
      if (ctl[i] !== e) begin
        errors++;
        $display("FAIL ctl[%0d] t=%0t got %b want %b", i, $time, ctl[i], e);
      end
      checks++;
      if (stc[i] !== 16'(scnt[i])) begin
        errors++;
        $display("FAIL stall_cnt[%0d] t=%0t got %0d want %0d", i, $time, stc[i], scnt[i]);
      end
      checks++;
      if (flc[i] !== 16'(fcnt[i])) begin
        errors++;
        $display("FAIL flush_cnt[%0d] t=%0t got %0d want %0d", i, $time, flc[i], fcnt[i]);
      end
      if (rst) begin
        left[i] = 0; scnt[i] = 0; fcnt[i] = 0;
      end else begin
        if (!e[P_EXEN] && scnt[i] < mx) scnt[i]++;
        if (e[P_SEL] && fcnt[i] < mx) fcnt[i]++;
        if (left[i] > 0) left[i]--;
        else if (!hzdlu && EX_mdustart) left[i] = LATS[i];
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit r, input bit h, input bit s, input bit d, input bit y);
    @(posedge clk); #1;
    rst = r; hzdlu = h; EX_mdustart = s; EX_redirect = d; IF_ready = y;
    @(negedge clk); #1;
  endtask

  task automatic lit(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin left[i] = 0; scnt[i] = 0; fcnt[i] = 0; end
    repeat (2) @(posedge clk);

    // Reset in the middle of an MDU op on instance 0 (mdu_cnt = 10).
    step(0, 0, 1, 0, 1);
    lit("a_go_start", ctl[0][P_GO], 1);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    lit("rst_pcen", ctl[0][P_PCEN], 0);
    lit("rst_idf", ctl[0][P_IDF], 1);
    lit("rst_exf", ctl[0][P_EXF], 1);
    lit("rst_memf", ctl[0][P_MEMF], 1);
    step(1, 0, 0, 0, 1);
    lit("rst_done", ctl[0][P_DONE], 0);
    step(0, 0, 0, 0, 1);
    lit("post_rst_busy", ctl[0][P_BUSY], 0);
    lit("post_rst_done", ctl[0][P_DONE], 0);
    lit("post_rst_exen", ctl[0][P_EXEN], 1);
    lit("post_rst_stall", stc[0], 0);
    lit("post_rst_flush", flc[0], 0);

    // Load-use masks a simultaneous redirect; redirect taken next cycle.
    step(0, 1, 0, 1, 1);
    lit("lu_pcen", ctl[0][P_PCEN], 0);
    lit("lu_iden", ctl[0][P_IDEN], 0);
    lit("lu_exen", ctl[0][P_EXEN], 0);
    lit("lu_memf", ctl[0][P_MEMF], 1);
    lit("lu_sel", ctl[0][P_SEL], 0);
    step(0, 0, 0, 1, 1);
    lit("rd_sel", ctl[0][P_SEL], 1);
    lit("rd_idf", ctl[0][P_IDF], 1);
    lit("rd_exf", ctl[0][P_EXF], 1);
    lit("rd_flush_before", flc[0], 0);
    step(0, 0, 0, 0, 1);
    lit("rd_flush_after", flc[0], 1);
    lit("lu_stall_cnt", stc[0], 1);

    // MDU_LAT=4 (inst 1) and MDU_LAT=1 (inst 2) with EX_mdustart held.
    step(1, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 1, 0, 1);
      lit("b_go", ctl[1][P_GO], (k == 0) ? 1 : 0);
      lit("b_exen", ctl[1][P_EXEN], (k == 4) ? 1 : 0);
      lit("b_done", ctl[1][P_DONE], (k == 4) ? 1 : 0);
      if (k < 2) begin
        lit("c_exen", ctl[2][P_EXEN], k);
        lit("c_done", ctl[2][P_DONE], k);
      end
    end
    step(0, 0, 0, 0, 1);
    lit("b_stall_cnt", stc[1], 4);
    lit("c_stall_cnt", stc[2], 3);

    // Fetch wait: flush IF/ID when idle, hold it when MDU stalls.
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    lit("fw_pcen", ctl[0][P_PCEN], 0);
    lit("fw_idf", ctl[0][P_IDF], 1);
    step(0, 0, 1, 0, 0);
    lit("fw_go_idf", ctl[0][P_IDF], 0);
    step(0, 0, 0, 0, 0);
    lit("fw_busy_idf", ctl[0][P_IDF], 0);
    lit("fw_busy_iden", ctl[0][P_IDEN], 0);

    // Redirect overrides fetch wait.
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0);
    lit("rdw_pcen", ctl[0][P_PCEN], 1);
    lit("rdw_sel", ctl[0][P_SEL], 1);
    lit("rdw_idf", ctl[0][P_IDF], 1);
    lit("rdw_exf", ctl[0][P_EXF], 1);

    // 20 load-use cycles: 4-bit counter saturates.
    step(1, 0, 0, 0, 1);
    repeat (20) step(0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    lit("sat_b_stall", stc[1], 15);
    lit("sat_a_stall", stc[0], 20);

    // Randomized traffic, model-checked every cycle.
    for (int n = 0; n < 4000; n++) begin
      step($urandom_range(0, 63) == 0,
           $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 12,
           $urandom_range(0, 99) < 25,
           $urandom_range(0, 99) < 70);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It consumes the load-use hazard flag from the forwarding unit, EX-stage branch/jump redirects, multi-cycle MDU (mult/div) requests and instruction-fetch wait. It drives the PC enable, the per-stage pipeline-register enables and the bubble-insert controls. It owns the MDU latency counter and keeps saturating stall/flush performance counters.

Parameters:
MDU_LAT, 32, total EX stall cycles for a mult/div op including start cycle; legal range 1..255
CNT_W, 16, width of performance counters

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
hzdlu  input  1  load-use hazard from forwarding unit (EX needs MEM load result)
EX_redirect  input  1  branch taken / jump resolved in EX, PC must load target
EX_mdustart  input  1  EX holds a mult/div instruction
IF_ready  input  1  instruction memory returned valid fetch this cycle
IF_pcen  output  1  PC register enable
pc_sel  output  1  1 = PC loads redirect target, 0 = sequential
ID_en  output  1  IF/ID register enable
ID_flush  output  1  IF/ID captures bubble (nop) at next edge
EX_en  output  1  ID/EX register enable
EX_flush  output  1  ID/EX captures bubble at next edge
MEM_flush  output  1  EX/MEM captures bubble at next edge (EX/MEM always enabled)
mdu_go  output  1  one-cycle start pulse to MDU
mdu_busy  output  1  FSM in BUSY
mdu_done  output  1  release cycle, MDU result written to HI/LO at next edge
stall_cnt  output  CNT_W  cycles with EX_en=0 since reset, saturating
flush_cnt  output  CNT_W  accepted redirects since reset, saturating

Behaviour:
- Registered state: FSM {IDLE, BUSY}, 8-bit mdu_cnt, stall_cnt, flush_cnt. All other outputs combinational from state and inputs.
- Synchronous reset: FSM<=IDLE, mdu_cnt<=0, counters<=0. While rst=1: IF_pcen=0, pc_sel=0, ID_en=EX_en=1, ID_flush=EX_flush=MEM_flush=1, mdu_go=mdu_done=0, mdu_busy=0. Reset mid-MDU abandons the op with no mdu_done.
- Defaults (IDLE, no events): IF_pcen=ID_en=EX_en=1, all flushes 0, pc_sel=0.
- Priority in IDLE: hzdlu > EX_mdustart > EX_redirect; IF_ready is evaluated independently, subject to the rules below.
- Load-use (IDLE, hzdlu=1): IF_pcen=ID_en=EX_en=0, MEM_flush=1. EX_redirect and EX_mdustart are ignored this cycle because their operands are stale; they are re-evaluated next cycle. Stall lasts exactly as long as hzdlu is high (normally 1 cycle).
- MDU start (IDLE, EX_mdustart=1, hzdlu=0): mdu_go=1, IF_pcen=ID_en=EX_en=0, MEM_flush=1; next state BUSY, mdu_cnt<=MDU_LAT-1.
- BUSY, mdu_cnt!=0: same stall outputs, mdu_busy=1, mdu_cnt decrements. EX_mdustart, EX_redirect and hzdlu are ignored.
- BUSY, mdu_cnt==0: release cycle. mdu_busy=1, mdu_done=1, default enables, MEM_flush=0. Next state IDLE.
- Total stall cycles for an op = MDU_LAT exactly; MDU_LAT=1 gives start cycle then release.
- Redirect (IDLE, EX_redirect=1, no higher priority event): pc_sel=1, IF_pcen=1 regardless of IF_ready (the outstanding fetch is abandoned), ID_flush=1, EX_flush=1. flush_cnt increments.
- Fetch wait (IF_ready=0, no redirect taken): IF_pcen=0. ID_flush=1 only if ID_en=1 this cycle; if ID is stalled for another reason, the held instruction is never flushed.
- stall_cnt increments every non-reset cycle with EX_en=0. Both counters hold at 2^CNT_W-1.

Test Plan:
- Reset for 2 cycles mid-BUSY (mdu_cnt=10) -> during rst all flushes=1, IF_pcen=0; after release FSM IDLE, stall_cnt=flush_cnt=0, no mdu_done.
- hzdlu=1 for 1 cycle with EX_redirect=1 same cycle -> IF_pcen=ID_en=EX_en=0, MEM_flush=1, pc_sel=0, flush_cnt unchanged; next cycle redirect=1, hzdlu=0 -> pc_sel=1, ID_flush=EX_flush=1, flush_cnt=1.
- MDU_LAT=4, EX_mdustart held -> mdu_go on cycle 0 only, EX_en=0 for cycles 0-3, mdu_done=1 and EX_en=1 on cycle 4, stall_cnt=4; MDU_LAT=1 -> EX_en=0 for one cycle, mdu_done the next.
- IF_ready=0 in IDLE -> IF_pcen=0, ID_flush=1; IF_ready=0 during MDU BUSY -> ID_flush=0, IF/ID holds.
- EX_redirect=1 with IF_ready=0 -> IF_pcen=1, pc_sel=1, ID_flush=EX_flush=1.
- CNT_W=4, 20 consecutive load-use stall cycles -> stall_cnt saturates at 15.
